// File: rtl/h14tx_island_scheduler.sv
// rtl/h14tx_island_scheduler.sv - HDMI 1.4 data-island sequencer and packet-source arbiter
//
// Places data islands inside blanking, drives the preamble/guard/data-period flags and
// shares one packet assembler among NUM_SRC round-robin packet sources.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   en              allow new islands (an island already started always completes)
//   de              video data enable; rising inside an island aborts it
//   blank_left      cycles until de next rises (meaningful while de = 0)
//   src_req         per-source level request, held until src_ack
//   src_header      per-source 24-bit header, slot i at [24*i +: 24]
//   src_sub         per-source 4 x 56-bit subpackets, sub k of src i at [224*i+56*k +: 56]
//   src_ack         one-cycle capture pulse to the winning source
//   header, sub     registered packet contents for the assembler, sub k at [56*k +: 56]
//   di_preamble     island preamble period
//   di_guard        leading or trailing island guard band
//   di_active       packet data period
//   pkt_first       high on cycle 0 of each packet
//   counter         cycle index within the packet, 0..31
//   abort           one-cycle pulse when an island is killed by de

module h14tx_island_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int MAX_PKTS   = 18,
    parameter int VID_MARGIN = 12,
    parameter int CTRL_MIN   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   de,
    input  logic [11:0]            blank_left,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [NUM_SRC*24-1:0]  src_header,
    input  logic [NUM_SRC*224-1:0] src_sub,
    output logic [NUM_SRC-1:0]     src_ack,
    output logic [23:0]            header,
    output logic [223:0]           sub,
    output logic                   di_preamble,
    output logic                   di_guard,
    output logic                   di_active,
    output logic                   pkt_first,
    output logic [4:0]             counter,
    output logic                   abort
);

    localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Whole island (preamble + guard + one packet + guard) plus the video margin must fit
    // to start; a further packet only needs packet + trailing guard + margin.
    localparam logic [11:0] START_NEED = 12'(8 + 2 + 32 + 2 + VID_MARGIN);
    localparam logic [11:0] CONT_NEED  = 12'(32 + 2 + VID_MARGIN);
    localparam logic [4:0]  MAX_P      = 5'(MAX_PKTS);
    localparam logic [7:0]  CTRL_SAT   = 8'(CTRL_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LGUARD,
        S_PKT,
        S_TGUARD
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [4:0]      pkts_q, pkts_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [7:0]      ctrl_q, ctrl_d;
    logic [23:0]     header_q, header_d;
    logic [223:0]    sub_q, sub_d;
    logic            pre_q, pre_d;
    logic            guard_q, guard_d;
    logic            active_q, active_d;
    logic            first_q, first_d;
    logic [4:0]      counter_q, counter_d;
    logic            abort_q, abort_d;

    logic            capture;
    logic            found;
    logic [RW-1:0]   win;
    logic [RW-1:0]   rr_next;
    logic [23:0]     sel_header;
    logic [223:0]    sel_sub;

    // Round-robin: first requester at or above the pointer, else wrap to the lowest one.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && src_req[i] && (i >= int'(rr_q))) begin
                found = 1'b1;
                win   = RW'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && src_req[i]) begin
                found = 1'b1;
                win   = RW'(i);
            end
        end
    end

    always_comb begin
        sel_header = '0;
        sel_sub    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(win) == i) begin
                sel_header = src_header[24*i +: 24];
                sel_sub    = src_sub[224*i +: 224];
            end
        end
    end

    always_comb begin
        if (int'(win) == NUM_SRC - 1) begin
            rr_next = '0;
        end else begin
            rr_next = win + RW'(1);
        end
    end

    always_comb begin
        src_ack = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ack[i] = capture && found && (int'(win) == i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pkts_d   = pkts_q;
        rr_d     = rr_q;
        header_d = header_q;
        sub_d    = sub_q;
        capture  = 1'b0;
        abort_d  = 1'b0;

        // Control-period length seen so far; only idle, non-video cycles count.
        if (de || (state_q != S_IDLE)) begin
            ctrl_d = '0;
        end else if (ctrl_q != CTRL_SAT) begin
            ctrl_d = ctrl_q + 8'd1;
        end else begin
            ctrl_d = ctrl_q;
        end

        case (state_q)
            S_IDLE: begin
                if (en && !de && (ctrl_q == CTRL_SAT) && (|src_req) &&
                    (blank_left >= START_NEED)) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (cnt_q == 5'd7) begin
                    state_d = S_LGUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_LGUARD: begin
                if (cnt_q == 5'd1) begin
                    capture = 1'b1;
                    state_d = S_PKT;
                    cnt_d   = '0;
                    pkts_d  = 5'd1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_PKT: begin
                if (cnt_q == 5'd31) begin
                    if ((pkts_q < MAX_P) && (|src_req) && !de &&
                        (blank_left >= CONT_NEED)) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        pkts_d  = pkts_q + 5'd1;
                    end else begin
                        state_d = S_TGUARD;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_TGUARD: begin
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Video starting inside an island overrides everything, including a pending capture.
        if ((state_q != S_IDLE) && de) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            capture = 1'b0;
            abort_d = 1'b1;
        end

        if (capture) begin
            header_d = found ? sel_header : '0;
            sub_d    = found ? sel_sub : '0;
            rr_d     = found ? rr_next : rr_q;
        end

        pre_d     = (state_d == S_PRE);
        guard_d   = (state_d == S_LGUARD) || (state_d == S_TGUARD);
        active_d  = (state_d == S_PKT);
        first_d   = (state_d == S_PKT) && (cnt_d == 5'd0);
        counter_d = (state_d == S_PKT) ? cnt_d : 5'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pkts_q    <= '0;
            rr_q      <= '0;
            ctrl_q    <= '0;
            header_q  <= '0;
            sub_q     <= '0;
            pre_q     <= 1'b0;
            guard_q   <= 1'b0;
            active_q  <= 1'b0;
            first_q   <= 1'b0;
            counter_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkts_q    <= pkts_d;
            rr_q      <= rr_d;
            ctrl_q    <= ctrl_d;
            header_q  <= header_d;
            sub_q     <= sub_d;
            pre_q     <= pre_d;
            guard_q   <= guard_d;
            active_q  <= active_d;
            first_q   <= first_d;
            counter_q <= counter_d;
            abort_q   <= abort_d;
        end
    end

    assign header      = header_q;
    assign sub         = sub_q;
    assign di_preamble = pre_q;
    assign di_guard    = guard_q;
    assign di_active   = active_q;
    assign pkt_first   = first_q;
    assign counter     = counter_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_h14tx_island_scheduler.sv
// tb/tb_h14tx_island_scheduler.sv - directed self-checking bench for h14tx_island_scheduler

module tb_h14tx_island_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en;
    logic         de;
    logic [11:0]  blank_left;
    logic [3:0]   src_req;
    logic [3:0]   req_m2;
    logic [95:0]  src_header;
    logic [895:0] src_sub;

    logic [3:0]   src_ack, m2_ack;
    logic [23:0]  header, m2_header;
    logic [223:0] sub, m2_sub;
    logic         di_preamble, di_guard, di_active, pkt_first, abort;
    logic         m2_pre, m2_guard, m2_active, m2_first, m2_abort;
    logic [4:0]   counter, m2_counter;

    h14tx_island_scheduler dut (
        .clk(clk), .rst(rst), .en(en), .de(de), .blank_left(blank_left),
        .src_req(src_req), .src_header(src_header), .src_sub(src_sub),
        .src_ack(src_ack), .header(header), .sub(sub),
        .di_preamble(di_preamble), .di_guard(di_guard), .di_active(di_active),
        .pkt_first(pkt_first), .counter(counter), .abort(abort)
    );

    h14tx_island_scheduler #(.MAX_PKTS(2)) dut_m2 (
        .clk(clk), .rst(rst), .en(en), .de(de), .blank_left(blank_left),
        .src_req(req_m2), .src_header(src_header), .src_sub(src_sub),
        .src_ack(m2_ack), .header(m2_header), .sub(m2_sub),
        .di_preamble(m2_pre), .di_guard(m2_guard), .di_active(m2_active),
        .pkt_first(m2_first), .counter(m2_counter), .abort(m2_abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int cyc = 0, n_pre = 0, n_guard = 0, n_act = 0, n_pf = 0, n_abort = 0, excl_err = 0;
    int pre_start = 0, act_rel = -1, ack_rel = -1, last_flag = 0;
    int m2_npre = 0, m2_nguard = 0, m2_nact = 0;
    logic prev_pre = 1'b0, prev_act = 1'b0;
    int ack_log[$];
    int m2_ack_log[$];
    logic [23:0] hdr_log[$];
    logic [55:0] sub_log[$];
    logic [3:0] ack_s;

    int b_pre, b_guard, b_act, b_pf, b_ack, b_hdr, b_abort, b_m2pre, b_m2guard, b_m2act, b_m2ack;
    int w;

    function automatic logic [23:0] hv(input int i);
        return 24'hC0DE01 + 24'(i);
    endfunction

    function automatic logic [55:0] sv(input int i, input int k);
        return {8'(i), 8'(k), 40'h5A5A5A5A5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample_cycle();
        cyc++;
        if (!rst) begin
            if (di_preamble && !prev_pre) pre_start = cyc;
            if (di_active && !prev_act) act_rel = cyc - pre_start;
            prev_pre = di_preamble;
            prev_act = di_active;
            if (di_preamble) n_pre++;
            if (di_guard) n_guard++;
            if (di_active) n_act++;
            if (di_preamble || di_guard || di_active) last_flag = cyc;
            if ((int'(di_preamble) + int'(di_guard) + int'(di_active)) > 1) excl_err++;
            if (pkt_first) begin
                n_pf++;
                hdr_log.push_back(header);
                sub_log.push_back(sub[55:0]);
            end
            if (abort) n_abort++;
            for (int i = 0; i < 4; i++) begin
                if (src_ack[i]) begin
                    ack_log.push_back(i);
                    ack_rel = cyc - pre_start;
                end
                if (m2_ack[i]) m2_ack_log.push_back(i);
            end
            if (m2_pre) m2_npre++;
            if (m2_guard) m2_nguard++;
            if (m2_active) m2_nact++;
        end
    endtask

    // One clock: sample at the falling edge, then sources drop requests that were acked.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_cycle();
            ack_s = src_ack;
            @(posedge clk);
            #1;
            src_req = src_req & ~ack_s;
        end
    endtask

    task automatic snap();
        b_pre = n_pre; b_guard = n_guard; b_act = n_act; b_pf = n_pf;
        b_ack = ack_log.size(); b_hdr = hdr_log.size(); b_abort = n_abort;
        b_m2pre = m2_npre; b_m2guard = m2_nguard; b_m2act = m2_nact;
        b_m2ack = m2_ack_log.size();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        en = 1'b1;
        de = 1'b0;
        blank_left = 12'd200;
        src_req = 4'b0000;
        req_m2 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_header[24*i +: 24] = hv(i);
            for (int k = 0; k < 4; k++) src_sub[224*i + 56*k +: 56] = sv(i, k);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_preamble", 64'(di_preamble), 64'd0);
        chk("rst_guard", 64'(di_guard), 64'd0);
        chk("rst_active", 64'(di_active), 64'd0);
        chk("rst_pkt_first", 64'(pkt_first), 64'd0);
        chk("rst_counter", 64'(counter), 64'd0);
        chk("rst_abort", 64'(abort), 64'd0);
        chk("rst_header", 64'(header), 64'd0);
        chk("rst_sub", 64'(sub[63:0]), 64'd0);
        chk("rst_ack", 64'(src_ack), 64'd0);
        rst = 1'b0;

        // single source, single packet
        snap();
        src_req = 4'b0001;
        tick(80);
        chk("t1_pre_cycles", 64'(n_pre - b_pre), 64'd8);
        chk("t1_guard_cycles", 64'(n_guard - b_guard), 64'd4);
        chk("t1_pkt_cycles", 64'(n_act - b_act), 64'd32);
        chk("t1_pkt_first", 64'(n_pf - b_pf), 64'd1);
        chk("t1_ack_count", 64'(ack_log.size() - b_ack), 64'd1);
        if (ack_log.size() > b_ack) chk("t1_ack_src", 64'(ack_log[b_ack]), 64'd0);
        chk("t1_ack_cycle", 64'(ack_rel), 64'd9);
        chk("t1_hdr_latency", 64'(act_rel), 64'd10);
        if (hdr_log.size() > b_hdr) begin
            chk("t1_header", 64'(hdr_log[b_hdr]), 64'(hv(0)));
            chk("t1_sub0", 64'(sub_log[b_hdr]), 64'(sv(0, 0)));
        end
        chk("t1_island_len", 64'(last_flag - pre_start + 1), 64'd44);
        chk("t1_abort", 64'(n_abort - b_abort), 64'd0);

        // four sources from reset, round-robin 0..3
        do_reset();
        snap();
        src_req = 4'b1111;
        blank_left = 12'd1000;
        tick(200);
        chk("t2_pkt_cycles", 64'(n_act - b_act), 64'd128);
        chk("t2_ack_count", 64'(ack_log.size() - b_ack), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (ack_log.size() > b_ack + i) chk("t2_ack_order", 64'(ack_log[b_ack + i]), 64'(i));
            if (hdr_log.size() > b_hdr + i) chk("t2_hdr_order", 64'(hdr_log[b_hdr + i]), 64'(hv(i)));
        end
        chk("t2_island_len", 64'(last_flag - pre_start + 1), 64'd140);
        chk("t2_req_drained", 64'(src_req), 64'd0);

        // start-fit boundary
        snap();
        src_req = 4'b0100;
        blank_left = 12'd55;
        tick(60);
        chk("t3_no_island_55", 64'(n_pre - b_pre), 64'd0);
        chk("t3_no_ack_55", 64'(ack_log.size() - b_ack), 64'd0);
        snap();
        blank_left = 12'd56;
        tick(80);
        chk("t3_island_56", 64'(n_pre - b_pre), 64'd8);
        chk("t3_pkt_56", 64'(n_act - b_act), 64'd32);
        if (ack_log.size() > b_ack) chk("t3_ack_src", 64'(ack_log[b_ack]), 64'd2);
        if (hdr_log.size() > b_hdr) chk("t3_header", 64'(hdr_log[b_hdr]), 64'(hv(2)));

        // request withdrawn during preamble -> null packet
        snap();
        blank_left = 12'd200;
        src_req = 4'b0010;
        w = 0;
        while (!di_preamble && w < 40) begin tick(1); w++; end
        chk("t5a_pre_seen", 64'(di_preamble), 64'd1);
        src_req = 4'b0000;
        tick(60);
        chk("t5a_no_ack", 64'(ack_log.size() - b_ack), 64'd0);
        chk("t5a_pkt_cycles", 64'(n_act - b_act), 64'd32);
        if (hdr_log.size() > b_hdr) begin
            chk("t5a_null_header", 64'(hdr_log[b_hdr]), 64'd0);
            chk("t5a_null_sub", 64'(sub_log[b_hdr]), 64'd0);
        end

        // video enable inside packet -> abort
        snap();
        src_req = 4'b1000;
        w = 0;
        while (!(di_active && counter == 5'd5) && w < 60) begin tick(1); w++; end
        chk("t5b_pkt5_seen", 64'(di_active && counter == 5'd5), 64'd1);
        de = 1'b1;
        tick(1);
        chk("t5b_abort", 64'(abort), 64'd1);
        chk("t5b_active", 64'(di_active), 64'd0);
        chk("t5b_guard", 64'(di_guard), 64'd0);
        chk("t5b_preamble", 64'(di_preamble), 64'd0);
        chk("t5b_header_kept", 64'(header), 64'(hv(3)));
        chk("t5b_counter", 64'(counter), 64'd0);
        de = 1'b0;
        tick(1);
        chk("t5b_abort_pulse", 64'(abort), 64'd0);
        tick(20);
        chk("t5b_abort_count", 64'(n_abort - b_abort), 64'd1);
        chk("t5b_ack_count", 64'(ack_log.size() - b_ack), 64'd1);
        chk("t5b_exclusive", 64'(excl_err), 64'd0);

        // MAX_PKTS = 2 instance: two packets per island, next island resumes at src2
        do_reset();
        snap();
        blank_left = 12'd1000;
        req_m2 = 4'b1111;
        tick(185);
        req_m2 = 4'b0000;
        chk("t4_ack_count", 64'(m2_ack_log.size() - b_m2ack), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (m2_ack_log.size() > b_m2ack + i)
                chk("t4_ack_order", 64'(m2_ack_log[b_m2ack + i]), 64'(i));
        end
        chk("t4_pkt_cycles", 64'(m2_nact - b_m2act), 64'd128);
        chk("t4_pre_cycles", 64'(m2_npre - b_m2pre), 64'd16);
        chk("t4_guard_cycles", 64'(m2_nguard - b_m2guard), 64'd8);

        // asynchronous reset mid-packet, then pointer and control count restart
        blank_left = 12'd200;
        src_req = 4'b0100;
        w = 0;
        while (!(di_active && counter == 5'd10) && w < 80) begin tick(1); w++; end
        chk("t6_pkt10_seen", 64'(di_active && counter == 5'd10), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_active", 64'(di_active), 64'd0);
        chk("t6_counter", 64'(counter), 64'd0);
        chk("t6_header", 64'(header), 64'd0);
        chk("t6_sub", 64'(sub[63:0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        src_req = 4'b1111;
        snap();
        w = 0;
        while (!di_preamble && w < 40) begin tick(1); w++; end
        chk("t6_ctrl_restart", 64'(w), 64'd13);
        tick(15);
        if (ack_log.size() > b_ack) chk("t6_rr_reset", 64'(ack_log[b_ack]), 64'd0);
        else chk("t6_rr_ack_seen", 64'(ack_log.size() - b_ack), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
